// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - ADC capture sequencer: arm, optional rising trigger, decimation, FWFT sample FIFO
module adc_capture_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] adc_data_in,
  input  logic               adc_data_valid,
  input  logic               start,
  input  logic               abort,
  input  logic        [15:0] cfg_len,
  input  logic               cfg_trig_en,
  input  logic signed [15:0] cfg_trig_level,
  input  logic        [7:0]  cfg_decim,
  output logic signed [15:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [LVL_W-1:0]   fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic        [15:0] len_q;
  logic               trig_en_q;
  logic signed [15:0] level_q;
  logic        [7:0]  decim_q;
  logic               primed;
  logic signed [15:0] prev;
  logic        [7:0]  phase;
  logic        [16:0] cnt;

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic        abort_act;
  logic        rd;
  logic        fifo_full;
  logic        trig_hit;
  logic        proc;
  logic        accept;
  logic        wr;
  logic [16:0] cnt_inc;

  assign m_valid    = (fifo_level != '0);
  assign m_data     = mem[rd_ptr];
  assign busy       = (state == S_ARM) || (state == S_CAPTURE) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  assign abort_act  = abort && (state != S_IDLE);
  assign rd         = m_valid && m_ready;
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign trig_hit   = primed && (prev < level_q) && (adc_data_in >= level_q);
  // The triggering sample is consumed as the first capture sample in ARM itself.
  assign proc       = adc_data_valid && !abort_act &&
                      ((state == S_CAPTURE) || (state == S_ARM && trig_en_q && trig_hit));
  assign accept     = proc && (phase == 8'd0);
  assign wr         = accept && (!fifo_full || rd);
  assign cnt_inc    = cnt + {16'd0, accept};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (abort_act) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= adc_data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + {{(LVL_W-1){1'b0}}, wr} - {{(LVL_W-1){1'b0}}, rd};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      trig_en_q <= 1'b0;
      level_q   <= '0;
      decim_q   <= '0;
      primed    <= 1'b0;
      prev      <= '0;
      phase     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
    end else if (abort_act) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            trig_en_q <= cfg_trig_en;
            level_q   <= cfg_trig_level;
            decim_q   <= cfg_decim;
            overflow  <= 1'b0;
            cnt       <= '0;
            phase     <= '0;
            primed    <= 1'b0;
            state     <= (cfg_len == 16'd0) ? S_DONE : S_ARM;
          end
        end
        S_ARM: begin
          if (!trig_en_q) begin
            state <= S_CAPTURE;
          end else if (adc_data_valid && !trig_hit) begin
            primed <= 1'b1;
            prev   <= adc_data_in;
          end
        end
        S_DRAIN: begin
          if (fifo_level == '0 || (fifo_level == LVL_W'(1) && rd)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase

      if (proc) begin
        phase <= (phase == decim_q) ? 8'd0 : phase + 8'd1;
        cnt   <= cnt_inc;
        if (accept && !wr) overflow <= 1'b1;
        state <= (cnt_inc == {1'b0, len_q}) ? S_DRAIN : S_CAPTURE;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - table-driven and scoreboard bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] adc_data_in = '0;
  logic               adc_data_valid = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic        [15:0] cfg_len = '0;
  logic               cfg_trig_en = 1'b0;
  logic signed [15:0] cfg_trig_level = '0;
  logic        [7:0]  cfg_decim = '0;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [LW-1:0]      fifo_level;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .adc_data_in(adc_data_in), .adc_data_valid(adc_data_valid),
    .start(start), .abort(abort), .cfg_len(cfg_len), .cfg_trig_en(cfg_trig_en),
    .cfg_trig_level(cfg_trig_level), .cfg_decim(cfg_decim), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  typedef struct {
    int trig_en;
    int level;
    int decim;
    int len;
    int n_samp;
    int samp[10];
    int n_exp;
    int exp[8];
  } vec_t;

  vec_t        vecs[5];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) done_cnt++;
    if (reset_n && m_valid && m_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got m_data %0d, expected no beat", m_data);
      end else begin
        check("beat_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input int trig, input int lvl, input int decim, input int len);
    cfg_trig_en    = trig[0];
    cfg_trig_level = 16'(lvl);
    cfg_decim      = 8'(decim);
    cfg_len        = 16'(len);
    start          = 1'b1;
    tick(1);
    start          = 1'b0;
  endtask

  task automatic send(input int v);
    adc_data_in    = 16'(v);
    adc_data_valid = 1'b1;
    tick(1);
    adc_data_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 2000) begin
      tick(1);
      k++;
    end
    if (done_cnt == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done pulse, expected one within 2000 cycles", name);
    end
    tick(2);
  endtask

  task automatic run_vector(input int i);
    vec_t v;
    v = vecs[i];
    for (int j = 0; j < v.n_exp; j++) exp_q.push_back(16'(v.exp[j]));
    done_cnt = 0;
    beat_cnt = 0;
    m_ready  = 1'b1;
    start_cap(v.trig_en, v.level, v.decim, v.len);
    tick(2);
    for (int j = 0; j < v.n_samp; j++) send(v.samp[j]);
    wait_done($sformatf("v%0d", i));
    check($sformatf("v%0d_done_once", i), done_cnt, 1);
    check($sformatf("v%0d_beats", i), beat_cnt, v.n_exp);
    check($sformatf("v%0d_queue_left", i), exp_q.size(), 0);
    check($sformatf("v%0d_busy", i), {31'd0, busy}, 0);
    check($sformatf("v%0d_overflow", i), {31'd0, overflow}, 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0,   0, 4, 5, '{10, 20, 30, 40, 50, 0, 0, 0, 0, 0}, 4, '{10, 20, 30, 40, 0, 0, 0, 0}};
    vecs[1] = '{1, 100, 0, 2, 6, '{-5, 50, 99, 100, 120, 80, 0, 0, 0, 0}, 2, '{100, 120, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{1, 100, 0, 2, 5, '{150, 160, 50, 130, 140, 0, 0, 0, 0, 0}, 2, '{130, 140, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{0, 0,   2, 3, 9, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0}, 3, '{1, 4, 7, 0, 0, 0, 0, 0}};
    vecs[4] = '{1, 0,   1, 2, 6, '{-3, -1, 0, 5, 7, 9, 0, 0, 0, 0}, 2, '{0, 7, 0, 0, 0, 0, 0, 0}};

    tick(3);
    check("rst_m_data", {16'd0, m_data}, 0);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_level", {28'd0, fifo_level}, 0);
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 5; i++) run_vector(i);

    // Zero-length capture, then a start presented during DONE.
    done_cnt = 0;
    start_cap(0, 0, 0, 0);
    check("len0_done", {31'd0, done}, 1);
    check("len0_busy", {31'd0, busy}, 0);
    check("len0_m_valid", {31'd0, m_valid}, 0);
    start_cap(0, 0, 0, 0);
    check("done_start_done", {31'd0, done}, 0);
    check("done_start_busy", {31'd0, busy}, 0);
    tick(1);
    check("done_start_ignored", {31'd0, done}, 0);
    tick(2);

    // Overflow with a stalled sink, then drain.
    done_cnt = 0;
    beat_cnt = 0;
    m_ready  = 1'b0;
    start_cap(0, 0, 0, 10);
    tick(2);
    for (int j = 1; j <= 10; j++) send(j);
    check("ovf_level", {28'd0, fifo_level}, DEPTH);
    check("ovf_flag", {31'd0, overflow}, 1);
    check("ovf_busy", {31'd0, busy}, 1);
    check("ovf_head", {16'd0, m_data}, 1);
    for (int j = 1; j <= 8; j++) exp_q.push_back(16'(j));
    m_ready = 1'b1;
    wait_done("ovf");
    check("ovf_beats", beat_cnt, 8);
    check("ovf_queue_left", exp_q.size(), 0);
    check("ovf_done_once", done_cnt, 1);
    check("ovf_sticky", {31'd0, overflow}, 1);

    // Abort with three samples buffered.
    done_cnt = 0;
    m_ready  = 1'b0;
    start_cap(0, 0, 0, 10);
    tick(2);
    send(5); send(6); send(7);
    check("abort_pre_level", {28'd0, fifo_level}, 3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_level", {28'd0, fifo_level}, 0);
    check("abort_m_valid", {31'd0, m_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    tick(3);
    check("abort_no_done", done_cnt, 0);
    run_vector(0);

    // Start while busy must not disturb the latched configuration.
    done_cnt = 0;
    beat_cnt = 0;
    m_ready  = 1'b1;
    exp_q.push_back(16'd120);
    start_cap(1, 100, 0, 1);
    tick(1);
    start_cap(0, 0, 0, 0);
    check("busy_start_busy", {31'd0, busy}, 1);
    tick(2);
    check("busy_start_still_armed", {31'd0, busy}, 1);
    check("busy_start_no_done", done_cnt, 0);
    send(150); send(50); send(120);
    wait_done("busy_start");
    check("busy_start_beats", beat_cnt, 1);
    check("busy_start_queue_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of a capture.
    m_ready = 1'b0;
    start_cap(0, 0, 0, 10);
    tick(2);
    send(3); send(4);
    check("areset_pre_valid", {31'd0, m_valid}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_m_data", {16'd0, m_data}, 0);
    check("areset_m_valid", {31'd0, m_valid}, 0);
    check("areset_busy", {31'd0, busy}, 0);
    check("areset_done", {31'd0, done}, 0);
    check("areset_overflow", {31'd0, overflow}, 0);
    check("areset_level", {28'd0, fifo_level}, 0);
    tick(2);
    reset_n = 1'b1;
    exp_q.delete();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
